// File: rtl/bp_nonsynth_stall_counter_bank.sv
// Stall-reason profiling counter bank: live saturating counters, an atomic shadow
// snapshot and a single-outstanding valid/ready read port onto the shadow bank.
module bp_nonsynth_stall_counter_bank #(
  parameter int num_reasons_p  = 32,
  parameter int reason_width_p = 5,
  parameter int cnt_width_p    = 32,
  parameter int addr_width_p   = 6
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      freeze_i,
  input  logic                      instret_i,
  input  logic                      stall_v_i,
  input  logic [reason_width_p-1:0] stall_reason_i,
  input  logic                      clear_i,
  input  logic                      snapshot_i,
  input  logic                      rd_v_i,
  input  logic [addr_width_p-1:0]   rd_addr_i,
  output logic                      rd_ready_o,
  output logic                      rd_v_o,
  output logic [cnt_width_p-1:0]    rd_data_o,
  input  logic                      rd_yumi_i,
  output logic                      ovf_o
);

  localparam int num_entries_lp = num_reasons_p + 3;
  localparam int idx_instret_lp = num_reasons_p;
  localparam int idx_cycle_lp   = num_reasons_p + 1;
  localparam int idx_unattr_lp  = num_reasons_p + 2;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_resp = 1'b1;

  logic [cnt_width_p-1:0]    live_r   [num_entries_lp];
  logic [cnt_width_p-1:0]    shadow_r [num_entries_lp];
  logic                      ovf_r;
  logic [0:0]                state_r;
  logic                      rd_ready_r;
  logic                      rd_v_r;
  logic [cnt_width_p-1:0]    rd_data_r;

  logic [num_reasons_p-1:0]  reason_hit_s;
  logic                      reason_ok_s;
  logic [num_entries_lp-1:0] inc_s;
  logic [num_entries_lp-1:0] at_max_s;
  logic                      ovf_set_s;
  logic [cnt_width_p-1:0]    rd_sel_s;

  // Decode the stall reason; encodings beyond the reason range hit nothing.
  always_comb begin
    reason_hit_s = '0;
    for (int i = 0; i < num_reasons_p; i++) begin
      reason_hit_s[i] = (stall_reason_i == reason_width_p'(i));
    end
    reason_ok_s = |reason_hit_s;
  end

  // Per-entry increment requests for this cycle.
  always_comb begin
    inc_s = '0;
    if (freeze_i) begin
      inc_s = '0;
    end else begin
      inc_s[idx_cycle_lp] = 1'b1;
      if (instret_i) begin
        inc_s[idx_instret_lp] = 1'b1;
      end else if (stall_v_i && reason_ok_s) begin
        inc_s[num_reasons_p-1:0] = reason_hit_s;
      end else begin
        inc_s[idx_unattr_lp] = 1'b1;
      end
    end
  end

  // Saturation detection and overflow request.
  always_comb begin
    at_max_s = '0;
    for (int i = 0; i < num_entries_lp; i++) begin
      at_max_s[i] = &live_r[i];
    end
    ovf_set_s = |(inc_s & at_max_s);
  end

  // Shadow read mux; unmapped addresses read as zero.
  always_comb begin
    rd_sel_s = '0;
    for (int i = 0; i < num_entries_lp; i++) begin
      rd_sel_s = rd_sel_s | (shadow_r[i] & {cnt_width_p{rd_addr_i == addr_width_p'(i)}});
    end
  end

  // Live counters, shadow capture and sticky overflow; clear wins over counting.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_entries_lp; i++) begin
        live_r[i]   <= '0;
        shadow_r[i] <= '0;
      end
      ovf_r <= 1'b0;
    end else begin
      if (snapshot_i) begin
        shadow_r <= live_r;
      end
      if (clear_i) begin
        for (int i = 0; i < num_entries_lp; i++) begin
          live_r[i] <= '0;
        end
        ovf_r <= 1'b0;
      end else begin
        for (int i = 0; i < num_entries_lp; i++) begin
          if (inc_s[i] && !at_max_s[i]) begin
            live_r[i] <= live_r[i] + cnt_width_p'(1);
          end
        end
        ovf_r <= ovf_r | ovf_set_s;
      end
    end
  end

  // Read port: accept in IDLE, hold the response in RESP until consumed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= st_idle;
      rd_ready_r <= 1'b1;
      rd_v_r     <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      case (state_r)
        st_idle: begin
          if (rd_v_i) begin
            rd_data_r  <= rd_sel_s;
            state_r    <= st_resp;
            rd_ready_r <= 1'b0;
            rd_v_r     <= 1'b1;
          end
        end
        st_resp: begin
          if (rd_yumi_i) begin
            state_r    <= st_idle;
            rd_ready_r <= 1'b1;
            rd_v_r     <= 1'b0;
          end
        end
        default: begin
          state_r    <= st_idle;
          rd_ready_r <= 1'b1;
          rd_v_r     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ready_o = rd_ready_r;
  assign rd_v_o     = rd_v_r;
  assign rd_data_o  = rd_data_r;
  assign ovf_o      = ovf_r;

  bp_nonsynth_stall_counter_bank_chk chk (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (clear_i),
    .snapshot_i (snapshot_i),
    .rd_yumi_i  (rd_yumi_i),
    .rd_v       (rd_v_r)
  );

endmodule

// Protocol checks on the counter bank's control inputs; simulation only.
module bp_nonsynth_stall_counter_bank_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic clear_i,
  input logic snapshot_i,
  input logic rd_yumi_i,
  input logic rd_v
);

  clear_is_pulse: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    clear_i |=> !clear_i);

  snapshot_is_pulse: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    snapshot_i |=> !snapshot_i);

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    rd_yumi_i |-> rd_v);

endmodule

// File: doc/bp_nonsynth_stall_counter_bank.md
Name: bp_nonsynth_stall_counter_bank

Overview:
- Synthesizable consumer of the core profiler's per-cycle stall classification: the retire flag plus the priority-encoded stall reason.
- Keeps one saturating counter per stall reason, plus instret, active-cycle and unattributed-cycle counters.
- A snapshot command copies all live counters atomically into a shadow bank.
- Host software reads the shadow bank through a single-outstanding valid/ready read port; a shell CSR bridge drives it on the FPGA.

Parameters:
num_reasons_p, 32, number of stall-reason encodings; live/shadow counters per reason.
reason_width_p, 5, width of stall_reason_i; equals clog2(num_reasons_p).
cnt_width_p, 32, width of every counter and of rd_data_o.
addr_width_p, 6, read address width; must cover num_reasons_p+3 entries.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; asynchronous assert, active-low, released synchronously by the shell
freeze_i  in  1  core frozen; no counting while high
instret_i  in  1  an instruction retired this cycle
stall_v_i  in  1  stall_reason_i is valid
stall_reason_i  in  reason_width_p  encoded stall reason
clear_i  in  1  zero all live counters (one-cycle pulse)
snapshot_i  in  1  copy live bank to shadow bank (one-cycle pulse)
rd_v_i  in  1  read request
rd_addr_i  in  addr_width_p  counter index
rd_ready_o  out  1  request accepted when rd_v_i & rd_ready_o
rd_v_o  out  1  read response valid
rd_data_o  out  cnt_width_p  shadow counter value
rd_yumi_i  in  1  response consumed
ovf_o  out  1  sticky: some live counter saturated since last clear

Behaviour:
- Reset (reset_n_i low, asynchronous): all live and shadow counters = 0; ovf_o = 0; read FSM = IDLE; rd_ready_o = 1; rd_v_o = 0; rd_data_o = 0.
- Counting (each cycle with freeze_i = 0):
  - instret_i = 1 -> instret counter +1; stall counters untouched.
  - instret_i = 0 and stall_v_i = 1 -> counter[stall_reason_i] +1.
  - instret_i = 0 and stall_v_i = 0 -> unattributed counter +1.
  - cycle counter +1 every unfrozen cycle.
  - Invariant after any unfrozen interval: cycle = instret + sum(reasons) + unattributed, absent saturation.
- stall_reason_i >= num_reasons_p with stall_v_i = 1: counts as unattributed.
- Saturation: a counter at 2^cnt_width_p-1 holds its value; the attempted increment sets ovf_o.
- clear_i: all live counters and ovf_o go to 0 on the next edge. Clear beats any same-cycle increment, so that cycle's event is dropped.
- snapshot_i: shadow[i] <= live[i] on the edge, for every i including non-reason counters.
  - The captured values exclude the same-cycle increment.
  - snapshot_i and clear_i together: the shadow gets the pre-clear values; the live bank is zeroed.
- Read map:
  - addr 0..num_reasons_p-1 -> reason counters.
  - num_reasons_p -> instret; num_reasons_p+1 -> cycle; num_reasons_p+2 -> unattributed.
  - Any other address -> data 0.
- Read FSM:
  - IDLE: rd_ready_o = 1. On rd_v_i, register shadow[rd_addr_i] into rd_data_o and go to RESP. Latency is 1 cycle: rd_v_o rises the cycle after acceptance.
  - RESP: rd_ready_o = 0; rd_v_o = 1; rd_data_o held stable until rd_yumi_i. On rd_yumi_i return to IDLE, with rd_v_o low next cycle.
  - No accept in the same cycle as yumi: back-to-back reads cost 2 cycles each.
- A snapshot during RESP does not alter the pending rd_data_o.
- rd_yumi_i while in IDLE is ignored.
- Reset mid-read: the response is dropped and the FSM returns to IDLE.
- Non-synthesizable checks (translate_off):
  - Assert clear_i and snapshot_i are never high two consecutive cycles.
  - Assert rd_yumi_i only when rd_v_o.

Test Plan:
- Reset then 10 unfrozen cycles with instret_i = 1 and stall_v_i = 0; snapshot; read addr 32 -> 10, addr 33 -> 10, addr 34 -> 0, addr 5 -> 0.
- Drive reason 7 for 4 cycles, reason 0 for 2 cycles, stall_v_i = 0 for 3 cycles, with freeze_i high for 5 further cycles; snapshot -> addr 7 = 4, addr 0 = 2, addr 34 = 3, addr 33 = 9.
- Preload a counter to 0xFFFF_FFFE by force; apply 3 stalls of that reason -> reads 0xFFFF_FFFF; ovf_o = 1; clear_i -> ovf_o = 0 and live counters 0.
- Same-cycle clear_i + snapshot_i after 6 instret cycles -> shadow addr 32 = 6; next snapshot with no activity reads 0.
- Issue rd_v_i at addr 33, withhold rd_yumi_i for 5 cycles while pulsing snapshot_i -> rd_data_o stable, rd_ready_o = 0 throughout; after yumi, next accept occurs 1 cycle later.
- Read addr 40 -> rd_data_o = 0. Drop reset_n_i during RESP -> rd_v_o = 0 immediately and all counters 0.
